// File: rtl/vms_countdown_timer_pkg.sv
// Shared definitions for the vending-machine countdown timer.
// Contents: the timer state encoding, the BCD digit width,
// the default BCD load value and a BCD-to-binary helper.
package vms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [7:0]  DEF_SEC_BCD = 8'h30;

    // Two-digit BCD to binary, used for the warning threshold compare.
    function automatic int unsigned bcd2bin(input logic [7:0] v);
        return 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
    endfunction

endpackage

// File: rtl/vms_countdown_timer_if.sv
// Command/status bundle between the control FSM and the countdown timer.
// master: control side (drives commands, reads status).
// slave : timer side (reads commands, drives status).
interface vms_countdown_timer_if;

    logic       i_tick;
    logic       i_clear;
    logic       i_load;
    logic [7:0] i_load_val;
    logic       i_start;
    logic       i_pause;
    logic [7:0] o_sec_bcd;
    logic       o_busy;
    logic       o_warn;
    logic       o_expire;

    modport master (
        output i_tick, i_clear, i_load, i_load_val, i_start, i_pause,
        input  o_sec_bcd, o_busy, o_warn, o_expire
    );

    modport slave (
        input  i_tick, i_clear, i_load, i_load_val, i_start, i_pause,
        output o_sec_bcd, o_busy, o_warn, o_expire
    );

endinterface

// File: rtl/vms_countdown_timer_bcd2_dec.sv
// Combinational two-digit BCD helper.
// i_val   : BCD value to decrement.
// i_raw   : raw BCD value to sanitise.
// o_dec   : i_val - 1 in BCD (ones digit wraps 0 -> 9 with borrow).
// o_is_one: i_val == 01.
// o_clamp : i_raw with each digit above 9 clamped to 9.
module bcd2_dec
    import vms_pkg::*;
(
    input  logic [7:0] i_val,
    input  logic [7:0] i_raw,
    output logic [7:0] o_dec,
    output logic       o_is_one,
    output logic [7:0] o_clamp
);

    logic [BCD_DIGIT_W-1:0] val_tens;
    logic [BCD_DIGIT_W-1:0] val_ones;
    logic [BCD_DIGIT_W-1:0] raw_tens;
    logic [BCD_DIGIT_W-1:0] raw_ones;

    assign val_tens = i_val[7:4];
    assign val_ones = i_val[3:0];
    assign raw_tens = i_raw[7:4];
    assign raw_ones = i_raw[3:0];

    always_comb begin
        o_dec   = i_val;
        o_clamp = i_raw;
        if (val_ones == '0) begin
            o_dec = {val_tens - 4'd1, 4'd9};
        end else begin
            o_dec = {val_tens, val_ones - 4'd1};
        end
        o_clamp[7:4] = (raw_tens > 4'd9) ? 4'd9 : raw_tens;
        o_clamp[3:0] = (raw_ones > 4'd9) ? 4'd9 : raw_ones;
    end

    assign o_is_one = (i_val == 8'h01);

endmodule

// File: rtl/vms_countdown_timer.sv
// Two-digit BCD countdown timer for the vending transaction timeout.
// i_clk, i_rst_n : system clock, asynchronous active-low reset.
// bus (slave)    : tick enable, clear/load/start/pause commands,
//                  BCD count, busy, warning and one-cycle expire pulse.
// The divider tick is used purely as a count enable.
module vms_countdown_timer
    import vms_pkg::*;
#(
    parameter int unsigned WARN_SEC = 5,
    parameter logic [7:0]  DEF_SEC  = DEF_SEC_BCD
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    vms_countdown_timer_if.slave bus
);

    state_t     state;
    state_t     nxt_state;
    logic [7:0] cnt;
    logic [7:0] nxt_cnt;
    logic [7:0] cnt_dec;
    logic [7:0] load_clamp;
    logic       cnt_is_one;
    logic       busy_q;
    logic       warn_q;
    logic       expire_q;

    bcd2_dec u_dec (
        .i_val    (cnt),
        .i_raw    (bus.i_load_val),
        .o_dec    (cnt_dec),
        .o_is_one (cnt_is_one),
        .o_clamp  (load_clamp)
    );

    // Priority: clear > load > start/pause > tick. A start in RUN is not
    // applicable, so a coincident tick still decrements.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        if (bus.i_clear) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
        end else if (bus.i_load) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = load_clamp;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        nxt_state = (cnt == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.i_pause) begin
                        nxt_state = ST_PAUSE;
                    end else if (bus.i_tick) begin
                        if (cnt_is_one) begin
                            nxt_state = ST_DONE;
                            nxt_cnt   = '0;
                        end else begin
                            nxt_cnt = cnt_dec;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.i_start) begin
                        nxt_state = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up
    // with the state/count registers without any input-to-output path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= DEF_SEC;
            busy_q   <= 1'b0;
            warn_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            busy_q   <= (nxt_state == ST_RUN) || (nxt_state == ST_PAUSE);
            warn_q   <= (nxt_state == ST_RUN) && (nxt_cnt != '0) &&
                        (bcd2bin(nxt_cnt) <= WARN_SEC);
            expire_q <= (nxt_state == ST_DONE) && (state != ST_DONE);
        end
    end

    assign bus.o_sec_bcd = cnt;
    assign bus.o_busy    = busy_q;
    assign bus.o_warn    = warn_q;
    assign bus.o_expire  = expire_q;

endmodule

// File: tb/tb_vms_countdown_timer.sv
module tb_vms_countdown_timer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vms_countdown_timer_if bus ();

    vms_countdown_timer #(
        .WARN_SEC (5),
        .DEF_SEC  (8'h30)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] sec;
        logic       busy;
        logic       warn;
        logic       expire;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   failures     = 0;
    int   dut_pulses   = 0;
    int   model_pulses = 0;

    // Reference model: plain integer seconds plus mode flags.
    int m_secs  = 30;
    bit m_run   = 1'b0;
    bit m_pause = 1'b0;
    bit m_done  = 1'b0;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'((s / 10) * 16 + (s % 10));
    endfunction

    function automatic int clamp_sec(input logic [7:0] v);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit tk, input bit cl, input bit ld,
                         input logic [7:0] v, input bit st, input bit ps);
        exp_t e;
        bit   idle;
        @(negedge clk);
        bus.i_tick     = tk;
        bus.i_clear    = cl;
        bus.i_load     = ld;
        bus.i_load_val = v;
        bus.i_start    = st;
        bus.i_pause    = ps;
        e.expire = 1'b0;
        idle = !m_run && !m_pause && !m_done;
        if (cl) begin
            m_secs = 0; m_run = 0; m_pause = 0; m_done = 0;
        end else if (ld) begin
            m_secs = clamp_sec(v); m_run = 0; m_pause = 0; m_done = 0;
        end else if (idle && st) begin
            if (m_secs == 0) begin
                m_done = 1; e.expire = 1'b1;
            end else begin
                m_run = 1;
            end
        end else if (m_run && ps) begin
            m_run = 0; m_pause = 1;
        end else if (m_pause && st) begin
            m_pause = 0; m_run = 1;
        end else if (m_run && tk) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_run = 0; m_done = 1; e.expire = 1'b1;
            end
        end
        if (e.expire) model_pulses++;
        e.sec  = to_bcd(m_secs);
        e.busy = m_run || m_pause;
        e.warn = m_run && (m_secs >= 1) && (m_secs <= 5);
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0, 0);
    endtask

    // One tick followed by three quiet cycles: a tick every 4 clocks.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 0, 8'h00, 0, 0);
            idle_cycles(3);
        end
    endtask

    task automatic zero_inputs();
        bus.i_tick = 0; bus.i_clear = 0; bus.i_load = 0;
        bus.i_load_val = 8'h00; bus.i_start = 0; bus.i_pause = 0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        zero_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_sec",    int'(bus.o_sec_bcd), 'h30);
        check("rst_busy",   int'(bus.o_busy),    0);
        check("rst_warn",   int'(bus.o_warn),    0);
        check("rst_expire", int'(bus.o_expire),  0);
        m_secs = 30; m_run = 0; m_pause = 0; m_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: the DUT presents a new status word after every clock edge.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {bus.o_sec_bcd, bus.o_busy, bus.o_warn, bus.o_expire};
                if (bus.o_expire) dut_pulses++;
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL status actual sec=%02h busy=%0b warn=%0b exp=%0b required sec=%02h busy=%0b warn=%0b exp=%0b at %0t",
                             act.sec, act.busy, act.warn, act.expire,
                             e.sec, e.busy, e.warn, e.expire, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        rst_n = 1'b0;
        #12;
        check("init_sec",    int'(bus.o_sec_bcd), 'h30);
        check("init_busy",   int'(bus.o_busy),    0);
        check("init_expire", int'(bus.o_expire),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal countdown 12 -> 00.
        cycle(0, 0, 1, 8'h12, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        ticks(12);
        idle_cycles(3);

        // Pause / resume.
        cycle(0, 0, 1, 8'h05, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        ticks(2);
        cycle(0, 0, 0, 8'h00, 0, 1);
        ticks(5);
        cycle(0, 0, 0, 8'h00, 1, 0);
        ticks(3);
        idle_cycles(2);

        // Priority collisions.
        cycle(0, 0, 1, 8'h09, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        cycle(1, 0, 1, 8'h20, 0, 0);
        cycle(0, 1, 1, 8'h55, 0, 0);
        cycle(0, 0, 1, 8'h07, 0, 0);
        cycle(1, 0, 0, 8'h00, 1, 0);
        cycle(0, 0, 0, 8'h00, 1, 1);
        cycle(0, 0, 0, 8'h00, 1, 1);
        cycle(1, 0, 0, 8'h00, 1, 0);
        idle_cycles(2);

        // Boundaries: clamp, start at zero, repeated start/tick in DONE.
        cycle(0, 0, 1, 8'hAF, 0, 0);
        cycle(0, 0, 1, 8'h7C, 0, 0);
        cycle(0, 0, 1, 8'hFF, 0, 0);
        cycle(0, 1, 0, 8'h00, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        cycle(1, 0, 0, 8'h00, 1, 0);
        idle_cycles(2);

        // Borrow across tens, then reset mid-count.
        cycle(0, 0, 1, 8'h41, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0);
        ticks(3);
        async_reset();
        idle_cycles(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                            : {4'd0, 4'($urandom_range(0, 15))};
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 29) == 0, v,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
        end
        idle_cycles(2);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        check("expire_pulses", dut_pulses, model_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vms_countdown_timer.md
Name: vms_countdown_timer

Overview:
- Two-digit BCD countdown timer for the vending machine transaction timeout.
- Sits directly downstream of the clock divider. It consumes the divider's one-cycle tick (high 1 cycle in every n) as a count enable. It never uses that tick as a clock.
- Loads a seconds value from the control FSM and counts down once per tick.
- Reports busy, warning and a one-cycle expire pulse back to the control FSM and the display.

Parameters:
- WARN_SEC, 5, RUN-state count at or below this value (decimal, compared after BCD-to-binary conversion) asserts o_warn.
- DEF_SEC, 8'h30, BCD value loaded at reset.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle count enable from the clock divider.
- i_clear  in  1  abort the countdown and zero the count.
- i_load  in  1  load i_load_val.
- i_load_val  in  8  BCD seconds: [7:4] tens, [3:0] ones.
- i_start  in  1  start, or resume from pause.
- i_pause  in  1  freeze the countdown.
- o_sec_bcd  out  8  current count in BCD.
- o_busy  out  1  high in RUN or PAUSE.
- o_warn  out  1  high in RUN when count <= WARN_SEC and count != 0.
- o_expire  out  1  one-cycle pulse when the count reaches 00 in RUN.

Behaviour:
- Clock, reset and registers
  - One clock domain. Reset is asynchronous and active-low on i_rst_n.
  - Reset values: state IDLE, o_sec_bcd = DEF_SEC, o_busy 0, o_warn 0, o_expire 0.
  - All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- States (2-bit): IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority per cycle (highest first): i_clear > i_load > i_start / i_pause > i_tick.
  - Only the highest-priority applicable command acts.
  - i_tick is ignored in any cycle where a command acts.
- i_clear (any state): count <= 00, state <= IDLE, no expire pulse.
- i_load (any state, no clear):
  - count <= sanitized i_load_val, state <= IDLE.
  - Sanitize: any digit > 9 is clamped to 9 (e.g. 8'h7C -> 8'h79, 8'hFF -> 8'h99).
- i_start
  - In IDLE with count != 00: state <= RUN.
  - In IDLE with count == 00: state <= DONE, o_expire pulses on the next cycle.
  - In PAUSE: state <= RUN, count unchanged.
  - Ignored in RUN and DONE.
- i_pause in RUN: state <= PAUSE. Ignored in all other states. If i_start and i_pause are both high, i_pause wins in RUN and i_start wins in PAUSE.
- RUN with i_tick and no command:
  - count != 01: BCD decrement. The ones digit wraps 0 -> 9 and borrows from tens (e.g. 8'h10 -> 8'h09, 8'h40 -> 8'h39).
  - count == 01: count <= 00, state <= DONE, o_expire <= 1 for exactly one cycle.
  - Latency: o_expire is high in the first cycle state reads DONE, i.e. 1 clock after the final tick edge.
- Ticks in IDLE, PAUSE and DONE are ignored.
- DONE holds 00 until i_clear or i_load. A tick or start in DONE does not re-pulse o_expire.
- Outputs per state:
  - o_busy = (state == RUN || state == PAUSE).
  - o_warn is 0 outside RUN.
- Reset mid-count: asynchronously returns to the reset values. No expire pulse is produced.

Decomposition:
- Shared package vms_pkg holds:
  - the state typedef/encoding (IDLE, RUN, PAUSE, DONE);
  - the BCD digit width (4);
  - DEF_SEC default.
- One natural sub-module: bcd2_dec.
  - Combinational 2-digit BCD decrement.
  - Outputs the decremented value and an is_one flag.
  - Also used for the digit clamp.

Test Plan:
- Reset: assert i_rst_n low mid-RUN -> o_sec_bcd=8'h30, o_busy=0, o_expire=0 immediately, without waiting for a clock edge.
- Normal countdown: load 8'h12, start, drive i_tick every 4 clocks. Required response:
  - sequence 12, 11, 10, 09, ..., 01, 00;
  - o_warn high from 05 to 01;
  - o_expire high exactly one cycle, 1 clock after the tick that produced 00;
  - o_busy falls at the same time.
- Pause/resume: load 8'h05, start, two ticks -> 03. Pause, then five ticks -> stays 03 with o_busy=1. Start, then three ticks -> 00 with one expire pulse.
- Priority collisions:
  - i_tick with i_load(8'h20) in RUN -> count 20, state IDLE.
  - i_clear with i_load -> count 00.
  - i_start with i_tick in IDLE at 8'h07 -> count 07, RUN.
- Boundaries:
  - load 8'hAF -> 8'h99;
  - start at 00 -> DONE plus one expire pulse;
  - repeated start in DONE -> no further pulse.
